io_output_bank: RTL
===================

IO_OUTPUT_BANK -- requirements
Module: io_output_bank

Interface
REQ-001 Parameter NPORTS, default 3: number of output ports; legal range 1..16.
REQ-002 Parameter PW, default 32: port width in bits; legal range 1..32; register bits above PW are not stored.
REQ-003 Parameter BASE_IDX, default 6'b100000: word index (addr[7:2]) of port 0.
REQ-004 io_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 clrn  input  1  reset; asynchronous, active-low.
REQ-006 addr  input  32  byte address; only addr[7:2] is decoded, addr[31:8] and addr[1:0] are ignored.
REQ-007 datain  input  32  write data.
REQ-008 byte_en  input  4  per-byte write enable; bit b qualifies datain[8b+7:8b].
REQ-009 write_io_enable  input  1  write request, sampled each rising edge.
REQ-010 read_io_enable  input  1  read request, sampled each rising edge.
REQ-011 dataout  output  32  registered read data.
REQ-012 out_port  output  NPORTS*PW  flattened port outputs; port i occupies bits [i*PW+PW-1 : i*PW].
REQ-013 port_strobe  output  NPORTS  one-cycle update pulse per port.

Function
REQ-014 idx = addr[7:2]; PORT i hit when idx == BASE_IDX+i, for i < NPORTS; STATUS hit at BASE_IDX+16; COMMIT hit at BASE_IDX+17; every other idx is unmapped.
REQ-015 A write with a PORT i hit updates only the bytes of port i whose byte_en bit is 1; all other bytes hold.
REQ-016 Write latency is 1: new out_port value is visible after the capturing edge; port_strobe[i] is high for exactly the following cycle, and pulses on every accepted write even when the data is unchanged or byte_en = 0.
REQ-017 A per-port sticky dirty[i] bit is set by every accepted write to port i.
REQ-018 A read of STATUS returns {16'b0, dirty zero-extended to 16 bits} and clears all dirty bits at the same edge.
REQ-019 When set and clear coincide in the same cycle, set wins for that port.
REQ-020 Read latency is 1: dataout is loaded at the edge where read_io_enable is sampled high, and holds its value on cycles with no read.
REQ-021 A PORT read returns the port register zero-extended from PW bits; an unmapped read returns 0.
REQ-022 A simultaneous read and write of the same port returns the pre-write value.
REQ-023 Writes to STATUS, COMMIT (when the feature is absent) or unmapped addresses have no effect; no error is signalled.

Reset
REQ-024 While clrn = 0: out_port, dirty, port_strobe, dataout and the shadow registers are all 0, independent of io_clk.
REQ-025 Reset asserted mid-pulse clears port_strobe immediately.
REQ-026 The first edge after release operates normally.

Configuration
REQ-027 Macro IO_OUT_SHADOW_EN selects double-buffered mode.
REQ-028 With IO_OUT_SHADOW_EN defined:
- PORT writes update shadow[i] only.
- PORT reads return shadow[i].
- A write to COMMIT copies shadow[i] to out_port i for each i with datain[i] = 1; port_strobe[i] pulses in the next cycle for exactly those ports.
- dirty[i] is still set by shadow writes.
- If a PORT write and a COMMIT coincide, the pre-write shadow value is committed.
REQ-029 Without IO_OUT_SHADOW_EN: no shadow storage exists; COMMIT is unmapped; behaviour is per REQ-015..023.

Structure
REQ-030 Shared package io_pkg holds:
- Constants IO_STATUS_OFS = 16 and IO_COMMIT_OFS = 17.
- The decode-result enumeration {HIT_PORT, HIT_STATUS, HIT_COMMIT, HIT_NONE}.
REQ-031 One sub-module, io_byte_reg: a PW-bit register with byte-enable load and asynchronous clear, instantiated once per port (and once per shadow when the feature is enabled).

Verification
REQ-032 Scenario 1, basic write: NPORTS=3, write 0xDEADBEEF with byte_en=4'hF to addr 0x84 -> out_port[63:32] = 0xDEADBEEF after 1 edge; port_strobe = 3'b010 for 1 cycle.
REQ-033 Scenario 2, partial write: write 0x11223344 with byte_en=4'b0101 to port 0 holding 0xAABBCCDD -> port 0 = 0xAA22CC44.
REQ-034 Scenario 3, dirty bits: write port 2, then read STATUS (addr 0xC0) -> dataout = 0x4; a second STATUS read -> 0x0. A STATUS read coinciding with a port-2 write -> next STATUS read = 0x4.
REQ-035 Scenario 4, unmapped and same-cycle access: write to addr 0x8C (NPORTS=3) -> no out_port change and no strobe; simultaneous read and write of port 1 (old 0x5, new 0x9) -> dataout = 0x5, then out_port1 = 0x9.
REQ-036 Scenario 5, shadow mode: with IO_OUT_SHADOW_EN, write 0x7 to port 0 -> out_port unchanged; write 0x1 to COMMIT (addr 0xC4) -> out_port0 = 0x7 and port_strobe = 3'b001. Assert clrn mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared decode constants and helpers for the output port bank.
//   IO_STATUS_OFS / IO_COMMIT_OFS : word offsets from BASE_IDX of the STATUS and COMMIT registers
//   io_hit_e                      : address decode result
//   io_decode()                   : classifies a word offset relative to BASE_IDX
package io_pkg;

    localparam int unsigned IO_STATUS_OFS = 16;
    localparam int unsigned IO_COMMIT_OFS = 17;

    typedef enum logic [1:0] {
        HIT_PORT,
        HIT_STATUS,
        HIT_COMMIT,
        HIT_NONE
    } io_hit_e;

    // ofs is (addr[7:2] - BASE_IDX) modulo 64.
    function automatic io_hit_e io_decode(input logic [5:0] ofs, input int unsigned nports);
        io_hit_e hit;
        if ({26'b0, ofs} < nports) begin
            hit = HIT_PORT;
        end else if ({26'b0, ofs} == IO_STATUS_OFS) begin
            hit = HIT_STATUS;
        end else if ({26'b0, ofs} == IO_COMMIT_OFS) begin
            hit = HIT_COMMIT;
        end else begin
            hit = HIT_NONE;
        end
        return hit;
    endfunction

endpackage

// File: rtl/io_output_bank_if.sv
// io_output_bank_if: register-access bus of the output port bank.
//   addr            : byte address (only [7:2] decoded)
//   datain          : write data
//   byte_en         : per-byte write qualifier
//   write_io_enable : write request
//   read_io_enable  : read request
//   dataout         : registered read data (driven by the slave)
interface io_output_bank_if;

    logic [31:0] addr;
    logic [31:0] datain;
    logic [3:0]  byte_en;
    logic        write_io_enable;
    logic        read_io_enable;
    logic [31:0] dataout;

    modport master (
        output addr,
        output datain,
        output byte_en,
        output write_io_enable,
        output read_io_enable,
        input  dataout
    );

    modport slave (
        input  addr,
        input  datain,
        input  byte_en,
        input  write_io_enable,
        input  read_io_enable,
        output dataout
    );

endinterface

// File: rtl/io_byte_reg.sv
// io_byte_reg: PW-bit register with per-byte load enable and asynchronous clear.
//   io_clk : clock
//   clrn   : asynchronous active-low clear
//   be     : byte load enables, be[b] covers bits [8b+7:8b]
//   d      : load data
//   q      : register contents
module io_byte_reg #(
    parameter int unsigned PW = 32
) (
    input  logic          io_clk,
    input  logic          clrn,
    input  logic [3:0]    be,
    input  logic [PW-1:0] d,
    output logic [PW-1:0] q
);

    logic [PW-1:0] bit_en;
    logic [PW-1:0] q_q;

    for (genvar b = 0; b < PW; b++) begin : g_bit_en
        assign bit_en[b] = be[b / 8];
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            q_q <= '0;
        end else begin
            q_q <= (q_q & ~bit_en) | (d & bit_en);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/io_output_bank.sv
// io_output_bank: bank of NPORTS memory-mapped output ports with dirty tracking.
//   io_clk      : clock
//   clrn        : asynchronous active-low reset
//   bus         : register-access bus (slave side)
//   out_port    : flattened port outputs, port i at [i*PW +: PW]
//   port_strobe : one-cycle pulse per port on each update
// Build option: define IO_OUT_SHADOW_EN for double-buffered ports (writes land in a shadow
// register and reach out_port only through a COMMIT write).
module io_output_bank
    import io_pkg::*;
#(
    parameter int unsigned NPORTS   = 3,
    parameter int unsigned PW       = 32,
    parameter logic [5:0]  BASE_IDX = 6'b100000
) (
    input  logic                 io_clk,
    input  logic                 clrn,
    io_output_bank_if.slave      bus,
    output logic [NPORTS*PW-1:0] out_port,
    output logic [NPORTS-1:0]    port_strobe
);

    logic [5:0]        ofs;
    io_hit_e           hit;
    logic [NPORTS-1:0] port_wr;
    logic [NPORTS-1:0] strobe_d;
    logic [NPORTS-1:0] strobe_q;
    logic [NPORTS-1:0] dirty_d;
    logic [NPORTS-1:0] dirty_q;
    logic              status_rd;
    logic [PW-1:0]     port_val [NPORTS];  // value a PORT read returns
    logic [31:0]       rdata;
    logic [31:0]       dataout_q;
    logic              unused_addr;

    assign ofs         = bus.addr[7:2] - BASE_IDX;
    assign hit         = io_decode(ofs, NPORTS);
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

    always_comb begin
        port_wr = '0;
        for (int i = 0; i < NPORTS; i++) begin
            port_wr[i] = bus.write_io_enable && (hit == HIT_PORT) && (ofs == 6'(i));
        end
    end

`ifdef IO_OUT_SHADOW_EN
    logic [NPORTS-1:0] commit_sel;

    always_comb begin
        commit_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            commit_sel[i] = bus.write_io_enable && (hit == HIT_COMMIT) && bus.datain[i];
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        logic [PW-1:0] shadow_q;

        io_byte_reg #(.PW(PW)) u_shadow (
            .io_clk (io_clk),
            .clrn   (clrn),
            .be     (port_wr[i] ? bus.byte_en : 4'b0000),
            .d      (bus.datain[PW-1:0]),
            .q      (shadow_q)
        );

        // Commit copies the registered shadow, so a coinciding PORT write is not seen.
        io_byte_reg #(.PW(PW)) u_live (
            .io_clk (io_clk),
            .clrn   (clrn),
            .be     ({4{commit_sel[i]}}),
            .d      (shadow_q),
            .q      (out_port[i*PW +: PW])
        );

        assign port_val[i] = shadow_q;
    end

    assign strobe_d = commit_sel;
`else
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        io_byte_reg #(.PW(PW)) u_live (
            .io_clk (io_clk),
            .clrn   (clrn),
            .be     (port_wr[i] ? bus.byte_en : 4'b0000),
            .d      (bus.datain[PW-1:0]),
            .q      (out_port[i*PW +: PW])
        );

        assign port_val[i] = out_port[i*PW +: PW];
    end

    assign strobe_d = port_wr;
`endif

    assign status_rd = bus.read_io_enable && (hit == HIT_STATUS);
    // Set is OR-ed in after the clear so a coinciding write keeps its dirty bit.
    assign dirty_d   = (dirty_q & ~{NPORTS{status_rd}}) | port_wr;

    always_comb begin
        rdata = '0;
        case (hit)
            HIT_PORT: begin
                for (int i = 0; i < NPORTS; i++) begin
                    if (ofs == 6'(i)) begin
                        rdata[PW-1:0] = port_val[i];
                    end
                end
            end
            HIT_STATUS: rdata[15:0] = 16'(dirty_q);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            strobe_q  <= '0;
            dirty_q   <= '0;
            dataout_q <= '0;
        end else begin
            strobe_q <= strobe_d;
            dirty_q  <= dirty_d;
            if (bus.read_io_enable) begin
                dataout_q <= rdata;
            end
        end
    end

    assign port_strobe = strobe_q;
    assign bus.dataout = dataout_q;

endmodule
